// File: rtl/module_control_operandos_pkg.sv
// Shared definitions for the keypad operand sequencer: FSM states, key codes,
// display-select codes and the default operand sizing.
package pkg_teclado;

   localparam int N_DIG_DEF = 3;   // max decimal digits per operand
   localparam int W_DEF     = 10;  // bits needed to hold 10^N_DIG-1

   typedef enum logic [2:0] {
      CAP_A,
      CAP_B,
      START,
      WAIT_MUL,
      SHOW
   } estado_e;

   localparam logic [3:0] K_ENTER = 4'd10;
   localparam logic [3:0] K_CLEAR = 4'd11;

   localparam logic [1:0] DISP_A   = 2'd0;
   localparam logic [1:0] DISP_B   = 2'd1;
   localparam logic [1:0] DISP_RES = 2'd2;

   function automatic logic es_digito(input logic [3:0] k);
      return (k < 4'd10);
   endfunction

endpackage

// File: rtl/module_control_operandos_acum.sv
// module_acum_bcd: combinational decimal shift-in, res = op*10 + digit.
// Ports:
//   op_i  [W-1:0]  current operand value
//   dig_i [3:0]    decimal digit 0-9
//   res_o [W-1:0]  op*10 + digit, truncated to W bits
module module_acum_bcd #(
   parameter int W = 10
) (
   input  logic [W-1:0] op_i,
   input  logic [3:0]   dig_i,
   output logic [W-1:0] res_o
);

   // x*10 = x*8 + x*2. Modular arithmetic gives the same low W bits as a
   // W+4 bit product, and the caller never lets the result exceed W bits.
   assign res_o = (op_i << 3) + (op_i << 1) + W'(dig_i);

endmodule

// File: rtl/module_control_operandos.sv
// module_control_operandos: sequencer between the keypad capture path and the
// multiplier. Accumulates decimal digits into operand A then B, fires a
// one-cycle multiplier start, waits for done, then holds a result phase.
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   tecla_valida_i  one-cycle key strobe
//   tecla_i [3:0]   key code: 0-9 digit, 10 ENTER, 11 CLEAR, 12-15 ignored
//   mult_listo_i    multiplier done (level, only looked at in WAIT_MUL)
//   mult_start_o    one-cycle start to the multiplier
//   op_a_o, op_b_o  operands (binary, W bits)
//   n_dig_o [1:0]   digits entered for the operand being captured
//   sel_disp_o[1:0] display select: 0 = A, 1 = B, 2 = result
//   ocupado_o       high while the multiplier is being started / running
//
// state    | meaning
// ---------+---------------------------------------------------------
// CAP_A    | capturing operand A digits
// CAP_B    | capturing operand B digits
// START    | one-cycle multiplier start strobe
// WAIT_MUL | waiting for mult_listo_i, operands frozen, keys dropped
// SHOW     | result displayed; a digit or CLEAR starts over
module module_control_operandos
   import pkg_teclado::*;
#(
   parameter int N_DIG = N_DIG_DEF,
   parameter int W     = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         tecla_valida_i,
   input  logic [3:0]   tecla_i,
   input  logic         mult_listo_i,
   output logic         mult_start_o,
   output logic [W-1:0] op_a_o,
   output logic [W-1:0] op_b_o,
   output logic [1:0]   n_dig_o,
   output logic [1:0]   sel_disp_o,
   output logic         ocupado_o
);

   localparam logic [1:0] N_MAX = 2'(N_DIG);

   estado_e        estado_q, estado_d;
   logic [W-1:0]   op_a_q, op_a_d;
   logic [W-1:0]   op_b_q, op_b_d;
   logic [1:0]     n_dig_q, n_dig_d;

   logic [W-1:0]   acum_in, acum_res;
   logic           k_dig, k_enter, k_clear, cabe_dig;

   // Single shared accumulator; only the operand being captured feeds it.
   assign acum_in = (estado_q == CAP_B) ? op_b_q : op_a_q;

   module_acum_bcd #(.W(W)) u_acum (
      .op_i  (acum_in),
      .dig_i (tecla_i),
      .res_o (acum_res)
   );

   assign k_dig    = tecla_valida_i && es_digito(tecla_i);
   assign k_enter  = tecla_valida_i && (tecla_i == K_ENTER);
   assign k_clear  = tecla_valida_i && (tecla_i == K_CLEAR);
   assign cabe_dig = (n_dig_q < N_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= CAP_A;
         op_a_q   <= '0;
         op_b_q   <= '0;
         n_dig_q  <= '0;
      end else begin
         estado_q <= estado_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         n_dig_q  <= n_dig_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      n_dig_d  = n_dig_q;
      unique case (estado_q)
         CAP_A: begin
            if (k_dig && cabe_dig) begin
               op_a_d  = acum_res;
               n_dig_d = n_dig_q + 2'd1;
            end else if (k_enter && (n_dig_q != 2'd0)) begin
               estado_d = CAP_B;
               n_dig_d  = '0;
            end else if (k_clear) begin
               op_a_d  = '0;
               n_dig_d = '0;
            end
         end
         CAP_B: begin
            if (k_dig && cabe_dig) begin
               op_b_d  = acum_res;
               n_dig_d = n_dig_q + 2'd1;
            end else if (k_enter && (n_dig_q != 2'd0)) begin
               estado_d = START;
            end else if (k_clear) begin
               op_a_d   = '0;
               op_b_d   = '0;
               n_dig_d  = '0;
               estado_d = CAP_A;
            end
         end
         START: estado_d = WAIT_MUL;
         WAIT_MUL: begin
            if (mult_listo_i) estado_d = SHOW;
         end
         SHOW: begin
            // A digit here is the first digit of the next operation.
            if (k_dig) begin
               op_a_d   = W'(tecla_i);
               op_b_d   = '0;
               n_dig_d  = 2'd1;
               estado_d = CAP_A;
            end else if (k_clear) begin
               op_a_d   = '0;
               op_b_d   = '0;
               n_dig_d  = '0;
               estado_d = CAP_A;
            end
         end
         default: estado_d = CAP_A;
      endcase
   end

   always_comb begin
      mult_start_o = 1'b0;
      ocupado_o    = 1'b0;
      sel_disp_o   = DISP_A;
      unique case (estado_q)
         CAP_A:    sel_disp_o = DISP_A;
         CAP_B:    sel_disp_o = DISP_B;
         START: begin
            sel_disp_o   = DISP_B;
            mult_start_o = 1'b1;
            ocupado_o    = 1'b1;
         end
         WAIT_MUL: begin
            sel_disp_o = DISP_B;
            ocupado_o  = 1'b1;
         end
         SHOW:     sel_disp_o = DISP_RES;
         default:  sel_disp_o = DISP_A;
      endcase
   end

   assign op_a_o  = op_a_q;
   assign op_b_o  = op_b_q;
   assign n_dig_o = n_dig_q;

endmodule
